// File: rtl/ex_mem_cplt.sv
// ex_mem_cplt: EX2 memory completion stage.
// Takes one load/store from EX1 and presents it on the bus until the bus answers.
// Completed loads are extended to 64 bits and written back through a one-cycle registered
// slot. A bus fault parks the stage in FLT until reset.
// Optional feature: define JX2_EX2_TIMEOUT_EN to turn a request that has been waiting for
// 255 cycles into a fault.
module ex_mem_cplt (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  exMemOpm,
    input  logic [31:0] exMemAddr,
    input  logic [63:0] exMemData,
    input  logic [5:0]  exHeldIdRn,
    input  logic        exHold,
    input  logic [1:0]  busOK,
    input  logic [63:0] busDataIn,
    output logic [4:0]  busOpm,
    output logic [31:0] busAddr,
    output logic [63:0] busDataOut,
    output logic [5:0]  regIdRn2,
    output logic [63:0] regValRn2,
    output logic        ex2Hold,
    output logic        ex2Fault
);

    localparam logic [5:0] Zzr       = 6'h3F;
    localparam logic [1:0] BusReady  = 2'b00;
    localparam logic [1:0] BusOk     = 2'b01;
    localparam logic [1:0] BusHold   = 2'b10;
    localparam logic [1:0] BusFault  = 2'b11;
    localparam logic [1:0] KindLoad  = 2'b01;

    typedef enum logic [1:0] {StIdle, StReq, StFlt} state_e;

    state_e      state_q, state_d;
    logic [4:0]  opm_q, opm_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic [5:0]  id_q, id_d;
    logic [5:0]  wb_id_q, wb_id_d;
    logic [63:0] wb_val_q, wb_val_d;
    logic        fault_q, fault_d;

    logic        ex_valid;
    logic        load_new;
    logic        tmo_hit;
    logic [1:0]  bus_rsp;

    assign ex_valid = (exMemOpm[4:3] != 2'b00) && !exHold;

    // Right-aligned bus data extended by access size; mode[2] selects zero-extension.
    function automatic logic [63:0] load_extend(input logic [2:0] mode, input logic [63:0] raw);
        logic [63:0] res;
        unique case (mode[1:0])
            2'b00:   res = {{56{raw[7]  & ~mode[2]}}, raw[7:0]};
            2'b01:   res = {{48{raw[15] & ~mode[2]}}, raw[15:0]};
            2'b10:   res = {{32{raw[31] & ~mode[2]}}, raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

`ifdef JX2_EX2_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;

    // An OK arriving on the expiry cycle still completes normally.
    assign tmo_hit = (state_q == StReq) && (tmo_q == 8'hFF) && (busOK != BusOk);

    // Wait counter: cleared on every REQ entry, counts cycles spent waiting on the bus.
    always_comb begin
        tmo_d = tmo_q;
        if (load_new) begin
            tmo_d = 8'd0;
        end else if (state_q == StReq && (bus_rsp == BusReady || bus_rsp == BusHold)) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign bus_rsp = tmo_hit ? BusFault : busOK;

    // FSM next state, request latch and writeback slot.
    always_comb begin
        state_d  = state_q;
        opm_d    = opm_q;
        addr_d   = addr_q;
        data_d   = data_q;
        id_d     = id_q;
        wb_id_d  = Zzr;
        wb_val_d = 64'd0;
        fault_d  = 1'b0;
        load_new = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    load_new = 1'b1;
                    state_d  = StReq;
                end
            end
            StReq: begin
                unique case (bus_rsp)
                    BusOk: begin
                        if (opm_q[4:3] == KindLoad) begin
                            wb_id_d  = id_q;
                            wb_val_d = load_extend(opm_q[2:0], busDataIn);
                        end
                        // A new op offered in the OK cycle starts without a bubble.
                        if (ex_valid) begin
                            load_new = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                    BusFault: begin
                        state_d = StFlt;
                        fault_d = 1'b1;
                    end
                    default: begin
                        state_d = StReq;
                    end
                endcase
            end
            StFlt: begin
                state_d = StFlt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load_new) begin
            opm_d  = exMemOpm;
            addr_d = exMemAddr;
            data_d = exMemData;
            id_d   = exHeldIdRn;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            opm_q    <= 5'd0;
            addr_q   <= 32'd0;
            data_q   <= 64'd0;
            id_q     <= Zzr;
            wb_id_q  <= Zzr;
            wb_val_q <= 64'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opm_q    <= opm_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            id_q     <= id_d;
            wb_id_q  <= wb_id_d;
            wb_val_q <= wb_val_d;
            fault_q  <= fault_d;
        end
    end

    // Bus request is only asserted in REQ; stall whenever the op cannot complete this cycle.
    always_comb begin
        busOpm     = (state_q == StReq) ? opm_q : 5'd0;
        busAddr    = addr_q;
        busDataOut = data_q;
        regIdRn2   = wb_id_q;
        regValRn2  = wb_val_q;
        ex2Fault   = fault_q;
        ex2Hold    = (state_q == StFlt) || ((state_q == StReq) && (bus_rsp != BusOk));
    end

endmodule

// File: tb/tb_ex_mem_cplt.sv
// tb_ex_mem_cplt: self-checking bench for ex_mem_cplt with randomized load/store traffic.
module tb_ex_mem_cplt;

    localparam logic [5:0] Zzr = 6'h3F;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  exMemOpm;
    logic [31:0] exMemAddr;
    logic [63:0] exMemData;
    logic [5:0]  exHeldIdRn;
    logic        exHold;
    logic [1:0]  busOK;
    logic [63:0] busDataIn;
    logic [4:0]  busOpm;
    logic [31:0] busAddr;
    logic [63:0] busDataOut;
    logic [5:0]  regIdRn2;
    logic [63:0] regValRn2;
    logic        ex2Hold;
    logic        ex2Fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ex_mem_cplt dut (
        .clock      (clock),
        .reset      (reset),
        .exMemOpm   (exMemOpm),
        .exMemAddr  (exMemAddr),
        .exMemData  (exMemData),
        .exHeldIdRn (exHeldIdRn),
        .exHold     (exHold),
        .busOK      (busOK),
        .busDataIn  (busDataIn),
        .busOpm     (busOpm),
        .busAddr    (busAddr),
        .busDataOut (busDataOut),
        .regIdRn2   (regIdRn2),
        .regValRn2  (regValRn2),
        .ex2Hold    (ex2Hold),
        .ex2Fault   (ex2Fault)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference load value: keep the low 8<<size bits, then fill upward with the sign or zero.
    function automatic logic [63:0] ref_load(input int size, input bit zext, input logic [63:0] raw);
        int          bits;
        logic [63:0] mask;
        logic [63:0] v;
        bits = 8 << size;
        if (bits == 64) return raw;
        mask = (64'd1 << bits) - 64'd1;
        v = raw & mask;
        if (!zext && raw[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic offer(input logic [4:0] opm, input logic [31:0] a, input logic [63:0] d,
                         input logic [5:0] id);
        exMemOpm   = opm;
        exMemAddr  = a;
        exMemData  = d;
        exHeldIdRn = id;
        exHold     = 1'b0;
    endtask

    task automatic withdraw();
        exMemOpm   = 5'd0;
        exMemAddr  = $urandom;
        exMemData  = {$urandom, $urandom};
        exHeldIdRn = 6'($urandom_range(0, 62));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        offer(5'b01011, 32'hDEAD_BEEF, 64'h1111_2222_3333_4444, 6'd9);
        busOK = 2'b01;
        busDataIn = {$urandom, $urandom};
        tick();
        tick();
        withdraw();
        busOK = 2'b00;
        settle();
        n_checks++; if (busOpm !== 5'd0) begin n_fail++; $display("FAIL reset busOpm: got %h want 0", busOpm); end
        n_checks++; if (busAddr !== 32'd0) begin n_fail++; $display("FAIL reset busAddr: got %h want 0", busAddr); end
        n_checks++; if (busDataOut !== 64'd0) begin n_fail++; $display("FAIL reset busDataOut: got %h want 0", busDataOut); end
        n_checks++; if (regIdRn2 !== Zzr) begin n_fail++; $display("FAIL reset regIdRn2: got %h want %h", regIdRn2, Zzr); end
        n_checks++; if (regValRn2 !== 64'd0) begin n_fail++; $display("FAIL reset regValRn2: got %h want 0", regValRn2); end
        n_checks++; if (ex2Hold !== 1'b0) begin n_fail++; $display("FAIL reset ex2Hold: got %b want 0", ex2Hold); end
        n_checks++; if (ex2Fault !== 1'b0) begin n_fail++; $display("FAIL reset ex2Fault: got %b want 0", ex2Fault); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_b();
        logic [63:0] raw;
        raw = {$urandom, $urandom};
        raw[7:0] = 8'h80;
        offer(5'b01000, 32'h0000_1000, 64'd0, 6'd5);
        settle();
        n_checks++; if (ex2Hold !== 1'b0) begin n_fail++; $display("FAIL ldb idle hold: got %b want 0", ex2Hold); end
        tick();
        withdraw();
        busOK = 2'b01;
        busDataIn = raw;
        settle();
        n_checks++; if (busOpm !== 5'b01000) begin n_fail++; $display("FAIL ldb busOpm: got %h want 08", busOpm); end
        n_checks++; if (busAddr !== 32'h1000) begin n_fail++; $display("FAIL ldb busAddr: got %h want 1000", busAddr); end
        n_checks++; if (ex2Hold !== 1'b0) begin n_fail++; $display("FAIL ldb ok hold: got %b want 0", ex2Hold); end
        tick();
        busOK = 2'b00;
        settle();
        n_checks++; if (regIdRn2 !== 6'd5) begin n_fail++; $display("FAIL ldb wb id: got %h want 05", regIdRn2); end
        n_checks++; if (regValRn2 !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL ldb wb val: got %h want ffffffffffffff80", regValRn2); end
        n_checks++; if (ex2Hold !== 1'b0) begin n_fail++; $display("FAIL ldb after hold: got %b want 0", ex2Hold); end
        tick();
        n_checks++; if (regIdRn2 !== Zzr) begin n_fail++; $display("FAIL ldb wb one cycle: got %h want %h", regIdRn2, Zzr); end
    endtask

    task automatic test_load_w_hold();
        offer(5'b01101, 32'h0000_3002, 64'd0, 6'd12);
        tick();
        withdraw();
        busOK = 2'b10;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++; if (ex2Hold !== 1'b1) begin n_fail++; $display("FAIL ldw hold cyc%0d: got %b want 1", i, ex2Hold); end
            tick();
        end
        busOK = 2'b01;
        busDataIn = {$urandom, 32'hABCD_8001};
        settle();
        n_checks++; if (ex2Hold !== 1'b0) begin n_fail++; $display("FAIL ldw ok hold: got %b want 0", ex2Hold); end
        tick();
        busOK = 2'b00;
        settle();
        n_checks++; if (regIdRn2 !== 6'd12) begin n_fail++; $display("FAIL ldw wb id: got %h want 0c", regIdRn2); end
        n_checks++; if (regValRn2 !== 64'h8001) begin n_fail++; $display("FAIL ldw wb val: got %h want 8001", regValRn2); end
        tick();
    endtask

    task automatic test_store_q();
        offer(5'b10011, 32'h0000_2008, 64'h0123_4567_89AB_CDEF, 6'd7);
        tick();
        for (int i = 0; i < 3; i++) begin
            withdraw();
            busOK = (i == 2) ? 2'b10 : 2'b00;
            busDataIn = {$urandom, $urandom};
            settle();
            n_checks++; if (busOpm !== 5'b10011) begin n_fail++; $display("FAIL stq busOpm cyc%0d: got %h want 13", i, busOpm); end
            n_checks++; if (busAddr !== 32'h2008) begin n_fail++; $display("FAIL stq busAddr cyc%0d: got %h want 2008", i, busAddr); end
            n_checks++; if (busDataOut !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL stq data cyc%0d: got %h want 0123456789abcdef", i, busDataOut); end
            tick();
        end
        busOK = 2'b01;
        tick();
        busOK = 2'b00;
        settle();
        n_checks++; if (regIdRn2 !== Zzr) begin n_fail++; $display("FAIL stq no wb: got %h want %h", regIdRn2, Zzr); end
        n_checks++; if (busOpm !== 5'd0) begin n_fail++; $display("FAIL stq idle busOpm: got %h want 0", busOpm); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] d1, d2;
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        offer(5'b01010, 32'h0000_4000, 64'd0, 6'd1);
        tick();
        offer(5'b01111, 32'h0000_5008, 64'd0, 6'd2);
        busOK = 2'b01;
        busDataIn = d1;
        settle();
        n_checks++; if (ex2Hold !== 1'b0) begin n_fail++; $display("FAIL b2b ok hold: got %b want 0", ex2Hold); end
        tick();
        withdraw();
        busDataIn = d2;
        settle();
        n_checks++; if (regIdRn2 !== 6'd1) begin n_fail++; $display("FAIL b2b wb1 id: got %h want 01", regIdRn2); end
        n_checks++; if (regValRn2 !== ref_load(2, 1'b0, d1)) begin n_fail++; $display("FAIL b2b wb1 val: got %h want %h", regValRn2, ref_load(2, 1'b0, d1)); end
        n_checks++; if (busOpm !== 5'b01111) begin n_fail++; $display("FAIL b2b second busOpm: got %h want 0f", busOpm); end
        n_checks++; if (busAddr !== 32'h5008) begin n_fail++; $display("FAIL b2b second addr: got %h want 5008", busAddr); end
        tick();
        busOK = 2'b00;
        settle();
        n_checks++; if (regIdRn2 !== 6'd2) begin n_fail++; $display("FAIL b2b wb2 id: got %h want 02", regIdRn2); end
        n_checks++; if (regValRn2 !== ref_load(3, 1'b1, d2)) begin n_fail++; $display("FAIL b2b wb2 val: got %h want %h", regValRn2, ref_load(3, 1'b1, d2)); end
        n_checks++; if (busOpm !== 5'd0) begin n_fail++; $display("FAIL b2b idle busOpm: got %h want 0", busOpm); end
        tick();
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 4; i++) begin
            offer(5'b01000, $urandom, {$urandom, $urandom}, 6'd3);
            exHold = 1'b1;
            busOK = (i % 2 == 0) ? 2'b01 : 2'b11;
            busDataIn = {$urandom, $urandom};
            tick();
            n_checks++; if (busOpm !== 5'd0) begin n_fail++; $display("FAIL idle busOpm cyc%0d: got %h want 0", i, busOpm); end
            n_checks++; if (ex2Fault !== 1'b0) begin n_fail++; $display("FAIL idle fault cyc%0d: got %b want 0", i, ex2Fault); end
            n_checks++; if (regIdRn2 !== Zzr) begin n_fail++; $display("FAIL idle wb cyc%0d: got %h want %h", i, regIdRn2, Zzr); end
            n_checks++; if (ex2Hold !== 1'b0) begin n_fail++; $display("FAIL idle hold cyc%0d: got %b want 0", i, ex2Hold); end
        end
        withdraw();
        exHold = 1'b0;
        busOK = 2'b00;
        tick();
    endtask

    task automatic test_random();
        bit          is_load;
        bit          zext;
        int          size;
        int          nwait;
        logic [4:0]  opm;
        logic [31:0] a;
        logic [63:0] d;
        logic [63:0] raw;
        logic [5:0]  id;
        for (int n = 0; n < 40; n++) begin
            is_load = 1'($urandom_range(0, 1));
            zext    = 1'($urandom_range(0, 1));
            size    = $urandom_range(0, 3);
            nwait   = $urandom_range(0, 4);
            a       = $urandom;
            d       = {$urandom, $urandom};
            raw     = {$urandom, $urandom};
            id      = 6'($urandom_range(0, 62));
            opm     = {(is_load ? 2'b01 : 2'b10), zext, 2'(size)};
            offer(opm, a, d, id);
            busOK = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                exHold = 1'b1;
                tick();
                n_checks++; if (busOpm !== 5'd0) begin n_fail++; $display("FAIL rnd held accept op%0d: got %h want 0", n, busOpm); end
                exHold = 1'b0;
            end
            tick();
            withdraw();
            for (int w = 0; w <= nwait; w++) begin
                busOK = (w == nwait) ? 2'b01 : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00);
                busDataIn = raw;
                settle();
                n_checks++; if (busOpm !== opm) begin n_fail++; $display("FAIL rnd busOpm op%0d: got %h want %h", n, busOpm, opm); end
                n_checks++; if (busAddr !== a) begin n_fail++; $display("FAIL rnd busAddr op%0d: got %h want %h", n, busAddr, a); end
                n_checks++; if (busDataOut !== d) begin n_fail++; $display("FAIL rnd busData op%0d: got %h want %h", n, busDataOut, d); end
                n_checks++; if (ex2Hold !== (w != nwait)) begin n_fail++; $display("FAIL rnd hold op%0d w%0d: got %b want %b", n, w, ex2Hold, (w != nwait)); end
                tick();
            end
            busOK = 2'($urandom_range(0, 3));
            settle();
            n_checks++; if (regIdRn2 !== (is_load ? id : Zzr)) begin n_fail++; $display("FAIL rnd wb id op%0d: got %h want %h", n, regIdRn2, (is_load ? id : Zzr)); end
            if (is_load) begin
                n_checks++; if (regValRn2 !== ref_load(size, zext, raw)) begin n_fail++; $display("FAIL rnd wb val op%0d: got %h want %h", n, regValRn2, ref_load(size, zext, raw)); end
            end
            n_checks++; if (busOpm !== 5'd0) begin n_fail++; $display("FAIL rnd idle busOpm op%0d: got %h want 0", n, busOpm); end
            tick();
            n_checks++; if (regIdRn2 !== Zzr) begin n_fail++; $display("FAIL rnd wb one cycle op%0d: got %h want %h", n, regIdRn2, Zzr); end
            n_checks++; if (ex2Fault !== 1'b0) begin n_fail++; $display("FAIL rnd stray fault op%0d: got %b want 0", n, ex2Fault); end
            busOK = 2'b00;
        end
    endtask

`ifdef JX2_EX2_TIMEOUT_EN
    task automatic test_timeout();
        int edges;
        edges = 0;
        offer(5'b01001, 32'h0000_6000, 64'd0, 6'd4);
        tick();
        withdraw();
        busOK = 2'b10;
        while (edges < 400 && ex2Fault !== 1'b1) begin
            tick();
            edges++;
        end
        n_checks++; if (edges !== 256) begin n_fail++; $display("FAIL timeout edges: got %0d want 256", edges); end
        n_checks++; if (ex2Hold !== 1'b1) begin n_fail++; $display("FAIL timeout hold: got %b want 1", ex2Hold); end
        n_checks++; if (busOpm !== 5'd0) begin n_fail++; $display("FAIL timeout busOpm: got %h want 0", busOpm); end
        reset = 1'b1;
        busOK = 2'b00;
        tick();
        reset = 1'b0;
        tick();
    endtask
`else
    task automatic test_wait_long();
        int bad;
        logic [63:0] raw;
        bad = 0;
        raw = {$urandom, $urandom};
        offer(5'b01001, 32'h0000_6000, 64'd0, 6'd4);
        tick();
        withdraw();
        busOK = 2'b10;
        for (int i = 0; i < 300; i++) begin
            settle();
            if (ex2Fault !== 1'b0 || ex2Hold !== 1'b1 || busOpm !== 5'b01001) bad++;
            tick();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL long wait cycles off: got %0d want 0", bad); end
        busOK = 2'b01;
        busDataIn = raw;
        tick();
        busOK = 2'b00;
        settle();
        n_checks++; if (regIdRn2 !== 6'd4) begin n_fail++; $display("FAIL long wait wb id: got %h want 04", regIdRn2); end
        n_checks++; if (regValRn2 !== ref_load(1, 1'b0, raw)) begin n_fail++; $display("FAIL long wait wb val: got %h want %h", regValRn2, ref_load(1, 1'b0, raw)); end
        tick();
    endtask
`endif

    task automatic test_reset_mid_req();
        offer(5'b01011, 32'h0000_7000, 64'd0, 6'd6);
        tick();
        withdraw();
        busOK = 2'b10;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        busOK = 2'b01;
        busDataIn = {$urandom, $urandom};
        settle();
        n_checks++; if (busOpm !== 5'd0) begin n_fail++; $display("FAIL rstreq busOpm: got %h want 0", busOpm); end
        n_checks++; if (ex2Hold !== 1'b0) begin n_fail++; $display("FAIL rstreq hold: got %b want 0", ex2Hold); end
        n_checks++; if (regIdRn2 !== Zzr) begin n_fail++; $display("FAIL rstreq wb0: got %h want %h", regIdRn2, Zzr); end
        tick();
        busOK = 2'b00;
        n_checks++; if (regIdRn2 !== Zzr) begin n_fail++; $display("FAIL rstreq wb1: got %h want %h", regIdRn2, Zzr); end
        n_checks++; if (busOpm !== 5'd0) begin n_fail++; $display("FAIL rstreq busOpm1: got %h want 0", busOpm); end
        tick();
    endtask

    task automatic test_fault();
        offer(5'b01010, 32'h0000_8000, 64'd0, 6'd8);
        tick();
        withdraw();
        busOK = 2'b10;
        tick();
        busOK = 2'b11;
        tick();
        busOK = 2'b01;
        offer(5'b01000, 32'h0000_9000, 64'd0, 6'd9);
        settle();
        n_checks++; if (ex2Fault !== 1'b1) begin n_fail++; $display("FAIL flt pulse: got %b want 1", ex2Fault); end
        n_checks++; if (busOpm !== 5'd0) begin n_fail++; $display("FAIL flt busOpm: got %h want 0", busOpm); end
        n_checks++; if (ex2Hold !== 1'b1) begin n_fail++; $display("FAIL flt hold: got %b want 1", ex2Hold); end
        n_checks++; if (regIdRn2 !== Zzr) begin n_fail++; $display("FAIL flt wb: got %h want %h", regIdRn2, Zzr); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (ex2Fault !== 1'b0) begin n_fail++; $display("FAIL flt pulse end cyc%0d: got %b want 0", i, ex2Fault); end
            n_checks++; if (ex2Hold !== 1'b1) begin n_fail++; $display("FAIL flt held cyc%0d: got %b want 1", i, ex2Hold); end
            n_checks++; if (busOpm !== 5'd0) begin n_fail++; $display("FAIL flt busOpm cyc%0d: got %h want 0", i, busOpm); end
            n_checks++; if (regIdRn2 !== Zzr) begin n_fail++; $display("FAIL flt wb cyc%0d: got %h want %h", i, regIdRn2, Zzr); end
        end
        withdraw();
        busOK = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        n_checks++; if (busOpm !== 5'd0) begin n_fail++; $display("FAIL flt rst busOpm: got %h want 0", busOpm); end
        n_checks++; if (ex2Hold !== 1'b0) begin n_fail++; $display("FAIL flt rst hold: got %b want 0", ex2Hold); end
        n_checks++; if (ex2Fault !== 1'b0) begin n_fail++; $display("FAIL flt rst fault: got %b want 0", ex2Fault); end
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        exHold    = 1'b0;
        busOK     = 2'b00;
        busDataIn = 64'd0;
        withdraw();
        test_reset();
        test_load_b();
        test_load_w_hold();
        test_store_q();
        test_back_to_back();
        test_idle_ignore();
        test_random();
`ifdef JX2_EX2_TIMEOUT_EN
        test_timeout();
`else
        test_wait_long();
`endif
        test_reset_mid_req();
        test_fault();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_cplt.md
EX_MEM_CPLT -- requirements
Module: ex_mem_cplt

Interface
REQ-001 clock  in  1  core clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 exMemOpm  in  5  EX1 memory op: [4:3] 01=load, 10=store, 00=none; [2] zero-extend; [1:0] size B/W/L/Q.
REQ-004 exMemAddr  in  32  EX1 effective address.
REQ-005 exMemData  in  64  EX1 store data.
REQ-006 exHeldIdRn  in  6  EX1 held load destination ID; ZZR means none.
REQ-007 exHold  in  1  EX1 hold; when 1, EX1 outputs are not accepted.
REQ-008 busOK  in  2  bus response: 00 READY, 01 OK, 10 HOLD, 11 FAULT.
REQ-009 busDataIn  in  64  load data, right-aligned, valid when busOK=01.
REQ-010 busOpm  out  5  request opcode to bus; READY (00000) when idle.
REQ-011 busAddr  out  32  request address.
REQ-012 busDataOut  out  64  store data.
REQ-013 regIdRn2  out  6  load writeback ID; ZZR when none.
REQ-014 regValRn2  out  64  load writeback value.
REQ-015 ex2Hold  out  1  pipeline stall request.
REQ-016 ex2Fault  out  1  one-cycle fault pulse.

Function
REQ-017 States: IDLE, REQ, FLT.
REQ-018 IDLE: if exMemOpm[4:3]!=00 and exHold=0, latch opm/addr/data/ID at edge and enter REQ; otherwise stay in IDLE.
REQ-019 REQ: busOpm/busAddr/busDataOut driven from latched registers, held stable until exit.
REQ-020 REQ with busOK=00 or 10: stay in REQ; ex2Hold=1 combinationally.
REQ-021 REQ with busOK=01: ex2Hold=0 that cycle; next edge returns to IDLE, or directly to REQ if a new valid EX1 op is present (back-to-back, no bubble).
REQ-022 Load completion: regIdRn2/regValRn2 are registered and valid for exactly one cycle after the OK edge; otherwise regIdRn2=ZZR.
REQ-023 Load extension by size: B bits [7:0], W bits [15:0], L bits [31:0], Q bits [63:0]; sign-extend from the top bit unless opm[2]=1, in which case zero-extend; busDataIn bits above the size are ignored.
REQ-024 Store completion: produces no writeback; regIdRn2 stays ZZR.
REQ-025 REQ with busOK=11: enter FLT; ex2Fault pulses 1 for one cycle on entry; no writeback is produced.
REQ-026 FLT: busOpm=READY, ex2Hold=1, and the state is held until reset.
REQ-027 busOK≠00 while in IDLE is ignored.
REQ-028 Address is passed through unmodified; no alignment check is performed.

Reset
REQ-029 On reset: state=IDLE, busOpm=READY, busAddr=0, busDataOut=0, regIdRn2=ZZR, regValRn2=0, ex2Hold=0, ex2Fault=0.
REQ-030 Reset mid-REQ abandons the request, with no writeback; any bus response in the cycle after reset is ignored.

Configuration
REQ-031 Macro JX2_EX2_TIMEOUT_EN: when defined, an 8-bit counter clears on REQ entry and increments each REQ cycle without OK or FAULT; reaching 255 is treated as busOK=11 (per REQ-025).
REQ-032 Without JX2_EX2_TIMEOUT_EN there is no counter, and REQ waits indefinitely.

Verification
REQ-033 Load B, addr 0x1000, opm=01_0_00, busOK=01 on first REQ cycle, data 0x..80 -> regValRn2=0xFFFFFFFFFFFFFF80 one cycle later, ex2Hold never 1.
REQ-034 Load W zero-ext (opm=01_1_01), busOK=10 for 3 cycles then 01 with data 0xABCD8001 -> ex2Hold=1 for 3 cycles, then regValRn2=0x8001.
REQ-035 Store Q addr 0x2008, data 0x0123456789ABCDEF -> busOpm=10_0_11 with stable addr/data until OK; regIdRn2 stays ZZR.
REQ-036 Back-to-back loads: the second op is presented during the first's OK cycle -> the second REQ starts on the next edge, giving two consecutive writebacks.
REQ-037 busOK=11 during REQ -> ex2Fault pulses once, ex2Hold stays 1, busOpm=READY until reset; reset -> IDLE.
REQ-038 With JX2_EX2_TIMEOUT_EN and busOK held at 10 -> fault is raised after 255 REQ cycles; reset asserted on cycle 10 of a REQ -> IDLE with no writeback.
